// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter and fetch controller sitting directly in front of the
// instruction ROM. It addresses the ROM with the current pc and captures the
// returned word into an instruction register (ir). The ir is offered
// downstream over a valid/ready handshake. The sequencer supports free-run and
// single-step operation, taken branches, and a halt opcode.
//
// Optional build macro: FETCH_COUNT_EN
//   When defined, an extra output fetch_count[7:0] reports the number of
//   completed handshakes. The count saturates at 255 and is cleared by reset
//   and by a restart from HALT.
//
// Ports:
//   clk            in   system clock; all state changes on its rising edge
//   reset_n        in   synchronous, active-low reset
//   start          in   pulse: leave IDLE, or restart from HALT at address 0
//   step_mode      in   1 = single-step mode, 0 = free-run mode
//   step           in   pulse: releases one fetch while waiting in step mode
//   instr_addr     out  ROM address (always equal to pc)
//   instr_in       in   ROM read data (asynchronous, same-cycle)
//   ir             out  registered instruction
//   ir_valid       out  ir holds an instruction not yet accepted downstream
//   ir_ready       in   downstream accepts ir this cycle
//   branch_en      in   redirect pc (looked at only in the handshake cycle)
//   branch_target  in   redirect address
//   pc             out  current program counter
//   fetch_count    out  handshake count (only with FETCH_COUNT_EN)
//   halted         out  sequencer is in HALT
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int         PC_W     = 3,
    parameter int         INSTR_W  = 12,
    parameter logic [2:0] HALT_OPC = 3'b111
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
`ifdef FETCH_COUNT_EN
    output logic [7:0]         fetch_count,
`endif
    output logic               halted
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_next;
    logic [INSTR_W-1:0]   r_ir;
    logic [INSTR_W-1:0]   w_ir_next;
    logic                 r_ir_valid;
    logic                 w_ir_valid_next;
    logic                 r_halted;
    logic                 w_halted_next;

    // Decoded helpers
    logic                 w_handshake;
    logic                 w_is_halt_opc;
    logic [PC_W-1:0]      w_pc_seq;
    logic                 w_restart;

    // A handshake can only occur while an instruction is being offered.
    assign w_handshake   = (r_state == S_ISSUE) && r_ir_valid && ir_ready;

    // The opcode lives in the top three bits of the instruction word.
    assign w_is_halt_opc = (r_ir[INSTR_W-1 -: 3] == HALT_OPC);

    // Sequential successor wraps naturally at 2^PC_W.
    assign w_pc_seq      = r_pc + PC_W'(1);

    // A start pulse only has meaning from IDLE or HALT; this one is the
    // restart case, which also rewinds pc and the optional counter.
    assign w_restart     = (r_state == S_HALT) && start;

    // -------------------------------------------------------------------------
    // Next-state and datapath update logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_ir_valid_next = r_ir_valid;
        w_halted_next   = r_halted;

        case (r_state)
            S_IDLE: begin
                // step is deliberately not looked at here; start alone leaves
                // IDLE, so start+step together behaves exactly like start.
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                // The ROM read is asynchronous, so the word for the current
                // pc is already on instr_in in this cycle.
                w_ir_next       = instr_in;
                w_ir_valid_next = 1'b1;
                w_state_next    = S_ISSUE;
            end

            S_ISSUE: begin
                // Without a handshake everything is held, keeping ir and
                // ir_valid stable for the consumer.
                if (w_handshake) begin
                    w_ir_valid_next = 1'b0;
                    if (w_is_halt_opc) begin
                        // pc stays on the halt instruction for inspection.
                        w_halted_next = 1'b1;
                        w_state_next  = S_HALT;
                    end else begin
                        w_pc_next    = branch_en ? branch_target : w_pc_seq;
                        w_state_next = step_mode ? S_WAIT_STEP : S_FETCH;
                    end
                end
            end

            S_WAIT_STEP: begin
                // Dropping step_mode while parked here resumes free-run.
                if (step || !step_mode) begin
                    w_state_next = S_FETCH;
                end
            end

            S_HALT: begin
                if (start) begin
                    w_pc_next     = '0;
                    w_halted_next = 1'b0;
                    w_state_next  = S_FETCH;
                end
            end

            default: begin
                // Unreachable encodings fall back to a clean idle.
                w_state_next    = S_IDLE;
                w_pc_next       = '0;
                w_ir_valid_next = 1'b0;
                w_halted_next   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers (reset overrides everything, including a handshake
    // happening in the same cycle)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_valid <= w_ir_valid_next;
            r_halted   <= w_halted_next;
        end
    end

`ifdef FETCH_COUNT_EN
    // -------------------------------------------------------------------------
    // Handshake counter: saturating, cleared by reset and by restart.
    // A halt instruction's handshake is counted like any other.
    // -------------------------------------------------------------------------
    logic [7:0] r_fetch_count;
    logic [7:0] w_fetch_count_next;

    always_comb begin
        w_fetch_count_next = r_fetch_count;
        if (w_restart) begin
            w_fetch_count_next = 8'd0;
        end else if (w_handshake && (r_fetch_count != 8'hFF)) begin
            w_fetch_count_next = r_fetch_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_count <= 8'd0;
        end else begin
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign instr_addr = r_pc;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign ir_valid   = r_ir_valid;
    assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. The ROM is an array in the bench,
// read combinationally from instr_addr. Directed scenarios cover reset, the
// basic fetch/issue sequence, back-pressure, branching and wrap, single-step
// mode, reset during issue and halt/restart. A randomized scenario checks the
// issued instruction stream against a behavioural model that walks the
// program with plain arithmetic (pc successor, branch, halt opcode).
// Define FETCH_COUNT_EN to also check the handshake counter.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  instr_addr;
    logic [11:0] instr_in;
    logic [11:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [2:0]  branch_target = 3'd0;
    logic [2:0]  pc;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [7:0]  fetch_count;
`endif

    logic [11:0] rom [8];
    assign instr_in = rom[instr_addr];

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .step_mode     (step_mode),
        .step          (step),
        .instr_addr    (instr_addr),
        .instr_in      (instr_in),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
`ifdef FETCH_COUNT_EN
        .fetch_count   (fetch_count),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        step = 1'b0;
        step_mode = 1'b0;
        ir_ready = 1'b0;
        branch_en = 1'b0;
        branch_target = 3'd0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic load_plain_rom();
        for (int i = 0; i < 8; i++) rom[i] = 12'h100 + 12'(i);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        load_plain_rom();
        do_reset();
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        vectors++; if (instr_addr !== 3'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", instr_addr); end
        vectors++; if (ir !== 12'h000) begin miscompares++; $display("FAIL reset_ir: got %03h expected 000", ir); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", ir_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
`ifdef FETCH_COUNT_EN
        vectors++; if (fetch_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`endif
        // No start: stays idle.
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", ir_valid); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_sequence_halt_restart();
        logic [11:0] words [4];
        logic        exp_v;
        words[0] = 12'h012; words[1] = 12'h312; words[2] = 12'h114; words[3] = 12'hE00;
        for (int i = 0; i < 8; i++) rom[i] = 12'h0AB;
        for (int i = 0; i < 4; i++) rom[i] = words[i];
        do_reset();
        ir_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = (k % 2 == 1) && (k <= 7);
            vectors++; if (ir_valid !== exp_v) begin miscompares++; $display("FAIL seq_valid k=%0d: got %b expected %b", k, ir_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (ir !== words[(k-1)/2]) begin miscompares++; $display("FAIL seq_ir k=%0d: got %03h expected %03h", k, ir, words[(k-1)/2]); end
            end
        end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL seq_halted: got %b expected 1", halted); end
        vectors++; if (pc !== 3'd3) begin miscompares++; $display("FAIL seq_halt_pc: got %0d expected 3", pc); end
        vectors++; if (ir !== 12'hE00) begin miscompares++; $display("FAIL seq_ir_kept: got %03h expected E00", ir); end
`ifdef FETCH_COUNT_EN
        vectors++; if (fetch_count !== 8'd4) begin miscompares++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
`endif
        // Restart from HALT.
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL restart_halted: got %b expected 0", halted); end
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL restart_pc: got %0d expected 0", pc); end
`ifdef FETCH_COUNT_EN
        vectors++; if (fetch_count !== 8'd0) begin miscompares++; $display("FAIL restart_count: got %0d expected 0", fetch_count); end
`endif
        tick();
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid: got %b expected 1", ir_valid); end
        vectors++; if (ir !== 12'h012) begin miscompares++; $display("FAIL restart_ir: got %03h expected 012", ir); end
        ir_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stall();
        rom[0] = 12'h012;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid k=%0d: got %b expected 1", k, ir_valid); end
            vectors++; if (ir !== 12'h012) begin miscompares++; $display("FAIL stall_ir k=%0d: got %03h expected 012", k, ir); end
            vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL stall_pc k=%0d: got %0d expected 0", k, pc); end
            if (k < 5) tick();
        end
        ir_ready = 1'b1;
        tick();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL stall_hs_valid: got %b expected 0", ir_valid); end
        vectors++; if (pc !== 3'd1) begin miscompares++; $display("FAIL stall_hs_pc: got %0d expected 1", pc); end
        ir_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_branch_wrap();
        load_plain_rom();
        do_reset();
        start = 1'b1; branch_en = 1'b1; branch_target = 3'd6;
        tick();
        start = 1'b0;
        tick();                                  // FETCH edge with branch_en high
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL br_ignored_fetch: got %0d expected 0", pc); end
        tick();                                  // stalled ISSUE with branch_en high
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL br_ignored_stall: got %0d expected 0", pc); end
        branch_en = 1'b0; ir_ready = 1'b1;
        tick();                                  // handshake, no branch
        vectors++; if (pc !== 3'd1) begin miscompares++; $display("FAIL br_seq_pc: got %0d expected 1", pc); end
        ir_ready = 1'b0; branch_en = 1'b1; branch_target = 3'd6;
        tick();                                  // FETCH of address 1
        vectors++; if (ir !== 12'h101) begin miscompares++; $display("FAIL br_ir1: got %03h expected 101", ir); end
        branch_target = 3'd5; ir_ready = 1'b1;
        tick();                                  // handshake with branch to 5
        vectors++; if (instr_addr !== 3'd5) begin miscompares++; $display("FAIL br_taken_addr: got %0d expected 5", instr_addr); end
        branch_en = 1'b0;
        tick();
        vectors++; if (ir !== 12'h105) begin miscompares++; $display("FAIL br_ir5: got %03h expected 105", ir); end
        branch_en = 1'b1; branch_target = 3'd7;
        tick();                                  // handshake with branch to 7
        vectors++; if (pc !== 3'd7) begin miscompares++; $display("FAIL br_to7: got %0d expected 7", pc); end
        branch_en = 1'b0;
        tick();
        vectors++; if (ir !== 12'h107) begin miscompares++; $display("FAIL br_ir7: got %03h expected 107", ir); end
        tick();                                  // sequential handshake from 7
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
        ir_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_step_mode();
        int nv;
        load_plain_rom();
        do_reset();
        step_mode = 1'b1; ir_ready = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        vectors++; if (ir_valid !== 1'b0 || pc !== 3'd0) begin miscompares++; $display("FAIL step_idle: got valid=%b pc=%0d expected valid=0 pc=0", ir_valid, pc); end
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        tick();
        vectors++; if (ir_valid !== 1'b1 || ir !== 12'h100) begin miscompares++; $display("FAIL step_first: got valid=%b ir=%03h expected valid=1 ir=100", ir_valid, ir); end
        tick();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (ir_valid !== 1'b0 || pc !== 3'd1) begin miscompares++; $display("FAIL step_park k=%0d: got valid=%b pc=%0d expected valid=0 pc=1", k, ir_valid, pc); end
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            nv = 0;
            for (int j = 0; j < 6; j++) begin
                tick();
                if (ir_valid === 1'b1) begin
                    nv++;
                    vectors++; if (ir !== 12'h101 + 12'(s)) begin miscompares++; $display("FAIL step_ir s=%0d: got %03h expected %03h", s, ir, 12'h101 + 12'(s)); end
                end
            end
            vectors++; if (nv != 1) begin miscompares++; $display("FAIL step_count s=%0d: got %0d expected 1", s, nv); end
            vectors++; if (pc !== 3'(2 + s)) begin miscompares++; $display("FAIL step_pc s=%0d: got %0d expected %0d", s, pc, 2 + s); end
        end
        // Step pulse during ISSUE must not pre-release the next fetch.
        ir_ready = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0; ir_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL step_issue_ignored k=%0d: got %b expected 0", k, ir_valid); end
        end
        vectors++; if (pc !== 3'd5) begin miscompares++; $display("FAIL step_issue_pc: got %0d expected 5", pc); end
        step_mode = 1'b0;
        tick(); tick();
        vectors++; if (ir_valid !== 1'b1 || ir !== 12'h105) begin miscompares++; $display("FAIL step_resume: got valid=%b ir=%03h expected valid=1 ir=105", ir_valid, ir); end
        tick(); tick();
        vectors++; if (ir_valid !== 1'b1 || ir !== 12'h106) begin miscompares++; $display("FAIL step_freerun: got valid=%b ir=%03h expected valid=1 ir=106", ir_valid, ir); end
        ir_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_issue();
        load_plain_rom();
        do_reset();
        ir_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); // handshake of address 0
        ir_ready = 1'b0;
        tick();         // address 1 offered
        vectors++; if (ir_valid !== 1'b1 || pc !== 3'd1) begin miscompares++; $display("FAIL mid_pre: got valid=%b pc=%0d expected valid=1 pc=1", ir_valid, pc); end
`ifdef FETCH_COUNT_EN
        vectors++; if (fetch_count !== 8'd1) begin miscompares++; $display("FAIL mid_pre_count: got %0d expected 1", fetch_count); end
`endif
        reset_n = 1'b0; ir_ready = 1'b1; start = 1'b1;
        tick();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b expected 0", ir_valid); end
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL mid_pc: got %0d expected 0", pc); end
        vectors++; if (ir !== 12'h000) begin miscompares++; $display("FAIL mid_ir: got %03h expected 000", ir); end
`ifdef FETCH_COUNT_EN
        vectors++; if (fetch_count !== 8'd0) begin miscompares++; $display("FAIL mid_count: got %0d expected 0", fetch_count); end
`endif
        reset_n = 1'b1; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL mid_idle k=%0d: got %b expected 0", k, ir_valid); end
        end
        ir_ready = 1'b0;
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_count_saturate();
        load_plain_rom();
        do_reset();
        ir_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 600; k++) tick();
        vectors++; if (fetch_count !== 8'd255) begin miscompares++; $display("FAIL count_sat: got %0d expected 255", fetch_count); end
        ir_ready = 1'b0;
    endtask
`endif

    // -------------------------------------------------------------------------
    // Randomized free-run against a program-walking model.
    // -------------------------------------------------------------------------
    task automatic test_random();
        int  exp_pc;
        int  exp_cnt;
        int  lag;         // edges still to go before the next instruction is offered
        bit  exp_halted;
        bit  exp_valid;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) rom[i] = 12'($urandom_range(0, 4095));
            do_reset();
            exp_pc = 0; exp_cnt = 0; exp_halted = 1'b0; lag = 2;
            for (int c = 0; c < 300; c++) begin
                ir_ready      = ($urandom_range(0, 3) != 0);
                branch_en     = $urandom_range(0, 1) == 1;
                branch_target = 3'($urandom_range(0, 7));
                start         = (c == 0) || ($urandom_range(0, 7) == 0);
                exp_valid     = !exp_halted && (lag == 0);

                vectors++; if (ir_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid r=%0d c=%0d: got %b expected %b", r, c, ir_valid, exp_valid); end
                vectors++; if (pc !== 3'(exp_pc) || instr_addr !== 3'(exp_pc)) begin miscompares++; $display("FAIL rnd_pc r=%0d c=%0d: got pc=%0d addr=%0d expected %0d", r, c, pc, instr_addr, exp_pc); end
                vectors++; if (halted !== exp_halted) begin miscompares++; $display("FAIL rnd_halted r=%0d c=%0d: got %b expected %b", r, c, halted, exp_halted); end
                if (exp_valid) begin
                    vectors++; if (ir !== rom[exp_pc]) begin miscompares++; $display("FAIL rnd_ir r=%0d c=%0d: got %03h expected %03h", r, c, ir, rom[exp_pc]); end
                end
`ifdef FETCH_COUNT_EN
                vectors++; if (fetch_count !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rnd_count r=%0d c=%0d: got %0d expected %0d", r, c, fetch_count, exp_cnt); end
`endif
                if (exp_halted) begin
                    if (start) begin
                        exp_pc = 0; exp_cnt = 0; exp_halted = 1'b0; lag = 2;
                    end
                end else if (exp_valid && ir_ready) begin
                    $display("hs r=%0d c=%0d pc=%0d ir=%03h br=%b tgt=%0d", r, c, exp_pc, rom[exp_pc], branch_en, branch_target);
                    if (exp_cnt < 255) exp_cnt++;
                    if (rom[exp_pc][11:9] == 3'b111) begin
                        exp_halted = 1'b1;
                    end else begin
                        exp_pc = branch_en ? int'(branch_target) : (exp_pc + 1) % 8;
                        lag = 2;
                    end
                end
                tick();
                if (lag > 0) lag--;
            end
        end
        start = 1'b0; ir_ready = 1'b0; branch_en = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_sequence_halt_restart();
        test_stall();
        test_branch_wrap();
        test_step_mode();
        test_reset_mid_issue();
`ifdef FETCH_COUNT_EN
        test_count_saturate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller directly upstream of the instruction ROM.
- Drives the ROM address and latches the returned 12-bit word into an instruction register (IR).
- Presents the IR to the downstream decode/execute stage over a valid/ready handshake.
- Supports free-run and single-step modes, taken branches, and a halt opcode.

Parameters:
- PC_W, 3: program counter / ROM address width.
- INSTR_W, 12: instruction width.
- HALT_OPC, 3'b111: value of instruction bits [INSTR_W-1:INSTR_W-3] that halts the sequencer.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetching from IDLE or restarts from HALT.
- step_mode  in  1  1 = single-step mode, 0 = free-run mode.
- step  in  1  one-cycle pulse; releases one fetch while in single-step mode.
- instr_addr  out  PC_W  ROM address, equal to pc (combinational).
- instr_in  in  INSTR_W  ROM read data (asynchronous read, valid in the same cycle).
- ir  out  INSTR_W  registered instruction.
- ir_valid  out  1  ir holds an instruction not yet accepted downstream.
- ir_ready  in  1  downstream accepts ir this cycle.
- branch_en  in  1  redirect pc; sampled only in the handshake cycle.
- branch_target  in  PC_W  redirect address.
- pc  out  PC_W  current program counter.
- halted  out  1  sequencer is in HALT.

Behaviour:
- Reset (reset_n=0 at a clk edge): pc=0, ir=0, ir_valid=0, halted=0, state=IDLE.
  - Reset takes priority over every other input in every state, including mid-handshake.
- instr_addr = pc at all times.
- States: IDLE, FETCH, ISSUE, WAIT_STEP, HALT.
- IDLE:
  - start=1 -> FETCH.
  - step is ignored, including when start and step are both 1 (start wins).
- FETCH (exactly 1 cycle): ir<=instr_in, ir_valid<=1 -> ISSUE.
- ISSUE:
  - ir and ir_valid are held stable while ir_ready=0.
  - Handshake occurs when ir_valid=1 and ir_ready=1; on that cycle ir_valid<=0.
  - If ir[INSTR_W-1:INSTR_W-3]==HALT_OPC: halted<=1, pc unchanged -> HALT.
  - Otherwise pc <= branch_en ? branch_target : pc+1, modulo 2^PC_W (7 -> 0 wraps).
  - Next state: step_mode=1 -> WAIT_STEP; step_mode=0 -> FETCH.
- WAIT_STEP:
  - step=1 -> FETCH.
  - step_mode=0 -> FETCH (leaving step mode resumes free-run).
  - Otherwise stay.
- HALT:
  - halted=1.
  - start=1: pc<=0, halted<=0 -> FETCH.
  - Otherwise stay.
- start is ignored in FETCH, ISSUE and WAIT_STEP.
- branch_en / branch_target are ignored outside the handshake cycle.
- Throughput: with ir_ready tied high, one instruction every 2 cycles.
- Latency: start to first ir_valid=1 is 2 clk edges (IDLE->FETCH, FETCH->ISSUE).
- ir keeps its last value after a handshake until the next FETCH.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- When defined:
  - Adds output port fetch_count[7:0], the number of completed handshakes.
  - Reset value 0; cleared on restart from HALT.
  - Increments on each handshake and saturates at 255.
  - A halt instruction's handshake counts.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start, ir_ready=1, ROM {0:12'h012, 1:12'h312, 2:12'h114, 3:12'hE00} -> ir shows 012, 312, 114, E00 on ir_valid cycles spaced 2 cycles apart; then halted=1, pc=3.
- ir_ready=0 for 5 cycles after first ir_valid -> ir=12'h012 and ir_valid=1 held stable throughout; pc stays 0 until the handshake.
- branch_en=1, branch_target=5 on the handshake of pc=1 -> next instr_addr=5; branch_en=1 outside handshake -> no effect.
- Free-run from pc=7 with a non-halt word -> pc wraps to 0.
- step_mode=1: exactly one instruction issued per step pulse; step with no pending WAIT_STEP ignored; dropping step_mode in WAIT_STEP resumes fetch.
- reset_n=0 during ISSUE with ir_valid=1 -> next cycle ir_valid=0, pc=0, IDLE; with FETCH_COUNT_EN, fetch_count=0; start from HALT clears halted and refetches address 0.
